// File: rtl/fibseq_engine_if.sv
// fibseq_engine_if -- result/term port bundle of fibseq_engine.
//   term_valid/term_data/term_ready : intermediate-term stream (valid/ready)
//   w_enable/result/ovf             : run-complete flag, final term, sticky overflow
// master = the engine, slave = the consumer.
interface fibseq_engine_if #(
   parameter int WIDTH = 32
);
   logic             term_valid;
   logic [WIDTH-1:0] term_data;
   logic             term_ready;
   logic             w_enable;
   logic [WIDTH-1:0] result;
   logic             ovf;

   modport master (
      output term_valid, term_data, w_enable, result, ovf,
      input  term_ready
   );

   modport slave (
      input  term_valid, term_data, w_enable, result, ovf,
      output term_ready
   );
endinterface

// File: rtl/fibseq_engine.sv
// fibseq_engine -- generalised Fibonacci (order 2..4) sequence engine.
// Each step sums the ORDER-term window, shifts it down by one and appends
// f(sum), where f is wrap, saturate or modulo.  The run length n, the initial
// window, mode, modulus and streaming option are captured on every cycle with
// r_enable=1, which also restarts the run.
// Ports:
//   clk        : clock, rising edge
//   r_enable   : synchronous load/restart (active high)
//   controlArr : reserved, ignored
//   init_n_t_a : step count
//   init_x_t_a : initial window, x[0] in the LSBs
//   mode       : 00 wrap, 01 saturate, 10 modulo, 11 wrap
//   mod_m      : modulus for modulo mode (0 = wrap)
//   stream_en  : offer every pre-step x[0] on the term port
//   bus        : term stream + result/w_enable/ovf (master side)
module fibseq_engine #(
   parameter int WIDTH = 32,
   parameter int NW    = 6,
   parameter int ORDER = 2
) (
   input  logic                   clk,
   input  logic                   r_enable,
   input  logic                   controlArr,
   input  logic [NW-1:0]          init_n_t_a,
   input  logic [ORDER*WIDTH-1:0] init_x_t_a,
   input  logic [1:0]             mode,
   input  logic [WIDTH-1:0]       mod_m,
   input  logic                   stream_en,
   fibseq_engine_if.master        bus
);

   typedef enum logic [1:0] {S_CHECK, S_EMIT, S_STEP, S_DONE} state_t;

   localparam int SW = WIDTH + 2;   // holds a sum of up to four terms

   logic unused_ctrl;
   assign unused_ctrl = controlArr;

   state_t           state_q, state_d;
   logic [NW-1:0]    n_q, n_d;
   logic [WIDTH-1:0] x_q [ORDER];
   logic [WIDTH-1:0] x_d [ORDER];
   logic [1:0]       mode_q, mode_d;
   logic [WIDTH-1:0] mod_q, mod_d;
   logic             stream_q, stream_d;
   logic             term_valid_q, term_valid_d;
   logic [WIDTH-1:0] term_data_q, term_data_d;
   logic             w_enable_q, w_enable_d;
   logic [WIDTH-1:0] result_q, result_d;
   logic             ovf_q, ovf_d;

   // sum of the window and its reduced value f(sum)
   logic [SW-1:0]    sum;
   logic [SW-1:0]    rem;
   logic [WIDTH-1:0] fx;
   logic             fx_ovf;
   logic             big;

   always_comb begin
      sum = '0;
      for (int i = 0; i < ORDER; i++) sum = sum + {2'b00, x_q[i]};
      big    = |sum[SW-1:WIDTH];
      rem    = sum;
      fx     = sum[WIDTH-1:0];
      fx_ovf = big;
      case (mode_q)
         2'b01: begin
            fx     = big ? {WIDTH{1'b1}} : sum[WIDTH-1:0];
            fx_ovf = big;
         end
         2'b10: begin
            if (mod_q != '0) begin
               // Terms stay below m, so the sum is below ORDER*m and
               // ORDER-1 conditional subtractions reduce it exactly.
               for (int k = 1; k < ORDER; k++) begin
                  if (rem >= {2'b00, mod_q}) rem = rem - {2'b00, mod_q};
               end
               fx     = rem[WIDTH-1:0];
               fx_ovf = 1'b0;
            end
         end
         default: ;
      endcase
   end

   always_comb begin
      state_d      = state_q;
      n_d          = n_q;
      x_d          = x_q;
      mode_d       = mode_q;
      mod_d        = mod_q;
      stream_d     = stream_q;
      term_valid_d = term_valid_q;
      term_data_d  = term_data_q;
      w_enable_d   = w_enable_q;
      result_d     = result_q;
      ovf_d        = ovf_q;
      if (r_enable) begin
         state_d  = S_CHECK;
         n_d      = init_n_t_a;
         for (int i = 0; i < ORDER; i++) x_d[i] = init_x_t_a[i*WIDTH +: WIDTH];
         mode_d       = mode;
         mod_d        = mod_m;
         stream_d     = stream_en;
         term_valid_d = 1'b0;   // a pending term is dropped here
         term_data_d  = '0;
         w_enable_d   = 1'b0;
         result_d     = '0;
         ovf_d        = 1'b0;
      end else begin
         case (state_q)
            S_CHECK: begin
               if (n_q == '0) begin
                  state_d    = S_DONE;
                  result_d   = x_q[0];
                  w_enable_d = 1'b1;
               end else if (stream_q) begin
                  state_d      = S_EMIT;
                  term_valid_d = 1'b1;
                  term_data_d  = x_q[0];
               end else begin
                  state_d = S_STEP;
               end
            end
            S_EMIT: begin
               if (bus.term_ready) begin
                  state_d      = S_STEP;
                  term_valid_d = 1'b0;
               end
            end
            S_STEP: begin
               for (int i = 0; i < ORDER - 1; i++) x_d[i] = x_q[i+1];
               x_d[ORDER-1] = fx;
               n_d          = (n_q != '0) ? n_q - 1'b1 : n_q;
               ovf_d        = ovf_q | fx_ovf;
               state_d      = S_CHECK;
            end
            default: ;   // S_DONE holds until the next r_enable
         endcase
      end
   end

   always_ff @(posedge clk) begin
      state_q      <= state_d;
      n_q          <= n_d;
      x_q          <= x_d;
      mode_q       <= mode_d;
      mod_q        <= mod_d;
      stream_q     <= stream_d;
      term_valid_q <= term_valid_d;
      term_data_q  <= term_data_d;
      w_enable_q   <= w_enable_d;
      result_q     <= result_d;
      ovf_q        <= ovf_d;
   end

   assign bus.term_valid = term_valid_q;
   assign bus.term_data  = term_data_q;
   assign bus.w_enable   = w_enable_q;
   assign bus.result     = result_q;
   assign bus.ovf        = ovf_q;

endmodule
